// File: rtl/host_line_responder.sv
// host_line_responder
//   Host-side cache-line responder. A line-addressed internal RAM is cleared
//   after reset. The block then serves one read or write request at a time.
//   Each request completes after a programmable latency through a
//   ready/strobe handshake.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   host_init                high once the post-reset clear has finished
//   host_rgo / host_wgo      one-cycle read / write request pulses
//   corrected_address        byte address, sampled with a request pulse
//   host_data_bus_read_in    read line toward the controller (0 when not valid)
//   host_rd_ready / host_re  read data valid / read data consumed
//   host_wr_ready / host_we  write data accepted / write data present
//   host_data_bus_write_out  write line from the controller
//   busy                     high whenever not idle
//   err                      one-cycle pulse per protocol or range error
module host_line_responder #(
  parameter int ADDR_BITCOUNT = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int DEPTH_LOG2    = 6,
  parameter int RD_LATENCY    = 4,
  parameter int WR_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     host_init,
  input  logic                     host_rgo,
  input  logic                     host_wgo,
  input  logic [ADDR_BITCOUNT-1:0] corrected_address,
  output logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in,
  output logic                     host_rd_ready,
  input  logic                     host_re,
  output logic                     host_wr_ready,
  input  logic                     host_we,
  input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out,
  output logic                     busy,
  output logic                     err
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_VALID = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_WR_READY = 3'd5
  } state_t;

  // An address is outside the RAM when any bit above the line index is set.
  function automatic logic addr_out_of_range(input logic [ADDR_BITCOUNT-1:0] addr);
    return (addr >> (DEPTH_LOG2 + 6)) != {ADDR_BITCOUNT{1'b0}};
  endfunction

  state_t                   state_r;
  logic [DEPTH_LOG2-1:0]    clear_cnt_r;
  logic [DEPTH_LOG2-1:0]    line_idx_r;
  logic [LAT_W-1:0]         lat_cnt_r;
  logic                     oor_r;
  logic [CL_SIZE_WIDTH-1:0] mem_r [DEPTH];

  logic                     req_oor_s;
  logic                     err_event_s;
  logic                     mem_we_s;
  logic [DEPTH_LOG2-1:0]    mem_waddr_s;
  logic [CL_SIZE_WIDTH-1:0] mem_wdata_s;

  assign req_oor_s = addr_out_of_range(corrected_address);

  // Error events: request collision or bad range when idle, any request while busy.
  always_comb begin
    err_event_s = 1'b0;
    case (state_r)
      ST_IDLE:     err_event_s = (host_rgo & host_wgo) | ((host_rgo | host_wgo) & req_oor_s);
      ST_RD_WAIT,
      ST_RD_VALID,
      ST_WR_WAIT,
      ST_WR_READY: err_event_s = host_rgo | host_wgo;
      default:     err_event_s = 1'b0;
    endcase
  end

  // RAM write port: zero fill during INIT, line write on the accepted write strobe.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = clear_cnt_r;
    mem_wdata_s = {CL_SIZE_WIDTH{1'b0}};
    case (state_r)
      ST_INIT: begin
        mem_we_s = 1'b1;
      end
      ST_WR_READY: begin
        if (host_we && !oor_r) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = line_idx_r;
          mem_wdata_s = host_data_bus_write_out;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Line storage; contents are defined by the INIT sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_event_s;
    end
  end

  // Main controller: clear sweep, request acceptance, latency count, handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r               <= ST_INIT;
      clear_cnt_r           <= {DEPTH_LOG2{1'b0}};
      line_idx_r            <= {DEPTH_LOG2{1'b0}};
      lat_cnt_r             <= {LAT_W{1'b0}};
      oor_r                 <= 1'b0;
      host_init             <= 1'b0;
      host_rd_ready         <= 1'b0;
      host_wr_ready         <= 1'b0;
      busy                  <= 1'b1;
      host_data_bus_read_in <= {CL_SIZE_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          clear_cnt_r <= clear_cnt_r + DEPTH_LOG2'(1);
          if (&clear_cnt_r) begin
            state_r   <= ST_IDLE;
            host_init <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_IDLE: begin
          // A simultaneous read and write request resolves to the read.
          if (host_rgo) begin
            state_r    <= ST_RD_WAIT;
            lat_cnt_r  <= LAT_W'(RD_LATENCY - 1);
            line_idx_r <= corrected_address[DEPTH_LOG2+5:6];
            oor_r      <= req_oor_s;
            busy       <= 1'b1;
          end else if (host_wgo) begin
            state_r    <= ST_WR_WAIT;
            lat_cnt_r  <= LAT_W'(WR_LATENCY - 1);
            line_idx_r <= corrected_address[DEPTH_LOG2+5:6];
            oor_r      <= req_oor_s;
            busy       <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_r               <= ST_RD_VALID;
            host_rd_ready         <= 1'b1;
            host_data_bus_read_in <= oor_r ? {CL_SIZE_WIDTH{1'b0}} : mem_r[line_idx_r];
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        ST_RD_VALID: begin
          if (host_re) begin
            state_r               <= ST_IDLE;
            host_rd_ready         <= 1'b0;
            host_data_bus_read_in <= {CL_SIZE_WIDTH{1'b0}};
            busy                  <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_r       <= ST_WR_READY;
            host_wr_ready <= 1'b1;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        ST_WR_READY: begin
          // The RAM write itself happens in the write-port logic on this edge.
          if (host_we) begin
            state_r       <= ST_IDLE;
            host_wr_ready <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state_r               <= ST_INIT;
          clear_cnt_r           <= {DEPTH_LOG2{1'b0}};
          host_init             <= 1'b0;
          host_rd_ready         <= 1'b0;
          host_wr_ready         <= 1'b0;
          busy                  <= 1'b1;
          host_data_bus_read_in <= {CL_SIZE_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_line_responder.sv
// Bench for host_line_responder. A timestamp-based model predicts every
// output on every cycle. It counts edges since reset and the age of the
// open transaction, and it keeps an array of lines. Directed handshake
// tasks add literal checks of latency, data and err pulse counts.
module tb_host_line_responder;
  localparam int AW     = 32;
  localparam int CW     = 512;
  localparam int NLINES = 64;
  localparam int RDL    = 4;
  localparam int WRL    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_init;
  logic          host_rgo = 1'b0;
  logic          host_wgo = 1'b0;
  logic [AW-1:0] corrected_address = 32'h0;
  logic [CW-1:0] host_data_bus_read_in;
  logic          host_rd_ready;
  logic          host_re = 1'b0;
  logic          host_wr_ready;
  logic          host_we = 1'b0;
  logic [CW-1:0] host_data_bus_write_out = '0;
  logic          busy;
  logic          err;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  bit noise_en = 1'b0;

  host_line_responder #(
    .ADDR_BITCOUNT(AW), .CL_SIZE_WIDTH(CW), .DEPTH_LOG2(6),
    .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host_init(host_init),
    .host_rgo(host_rgo), .host_wgo(host_wgo),
    .corrected_address(corrected_address),
    .host_data_bus_read_in(host_data_bus_read_in),
    .host_rd_ready(host_rd_ready), .host_re(host_re),
    .host_wr_ready(host_wr_ready), .host_we(host_we),
    .host_data_bus_write_out(host_data_bus_write_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [CW-1:0] mdl_mem [NLINES];
  int            mdl_edges;   // clock edges seen out of reset, saturating at NLINES
  int            mdl_kind;    // 0 none, 1 read, 2 write
  int            mdl_age;     // edges since the request was accepted
  int            mdl_line;
  bit            mdl_oor;
  logic          mdl_err;

  task automatic mdl_reset();
    for (int i = 0; i < NLINES; i++) mdl_mem[i] = '0;
    mdl_edges = 0;
    mdl_kind  = 0;
    mdl_age   = 0;
    mdl_line  = 0;
    mdl_oor   = 1'b0;
    mdl_err   = 1'b0;
  endtask

  task automatic mdl_step();
    logic e;
    e = 1'b0;
    if (mdl_edges < NLINES) begin
      mdl_edges++;
    end else if (mdl_kind == 0) begin
      if (host_rgo || host_wgo) begin
        mdl_kind = host_rgo ? 1 : 2;
        mdl_age  = 0;
        mdl_line = int'(corrected_address / 64) % NLINES;
        mdl_oor  = (corrected_address >= 32'(64 * NLINES));
        e = (host_rgo && host_wgo) || mdl_oor;
      end
    end else begin
      e = host_rgo || host_wgo;
      if (mdl_kind == 1 && mdl_age >= RDL && host_re) begin
        mdl_kind = 0;
      end else if (mdl_kind == 2 && mdl_age >= WRL && host_we) begin
        if (!mdl_oor) mdl_mem[mdl_line] = host_data_bus_write_out;
        mdl_kind = 0;
      end else begin
        mdl_age++;
      end
    end
    mdl_err = e;
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else mdl_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic          e_init, e_busy, e_rd, e_wr;
    logic [CW-1:0] e_data;
    forever begin
      @(negedge clk);
      e_init = (mdl_edges >= NLINES);
      e_busy = !e_init || (mdl_kind != 0);
      e_rd   = (mdl_kind == 1) && (mdl_age >= RDL);
      e_wr   = (mdl_kind == 2) && (mdl_age >= WRL);
      e_data = (e_rd && !mdl_oor) ? mdl_mem[mdl_line] : '0;
      check("m_host_init", host_init, e_init);
      check("m_busy", busy, e_busy);
      check("m_err", err, mdl_err);
      check("m_rd_ready", host_rd_ready, e_rd);
      check("m_wr_ready", host_wr_ready, e_wr);
      check("m_rd_data", host_data_bus_read_in, e_data);
    end
  end

  // Count err pulses (value visible in the cycle before each edge).
  always @(posedge clk) if (err === 1'b1) err_seen <= err_seen + 1;

  // ---------------- handshake drivers ----------------
  task automatic read_noise();
    host_rgo = 1'b0; host_wgo = 1'b0; host_we = 1'b0;
    if (noise_en) begin
      if ($urandom_range(7) == 0) begin
        host_rgo = 1'b1;
        corrected_address = $urandom;
      end
      if ($urandom_range(7) == 0) host_wgo = 1'b1;
      if ($urandom_range(3) == 0) host_we = 1'b1;
    end
  endtask

  task automatic write_noise();
    host_rgo = 1'b0; host_wgo = 1'b0; host_re = 1'b0;
    if (noise_en) begin
      if ($urandom_range(7) == 0) host_rgo = 1'b1;
      if ($urandom_range(7) == 0) begin
        host_wgo = 1'b1;
        corrected_address = $urandom;
      end
      if ($urandom_range(3) == 0) host_re = 1'b1;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit inj_wgo,
                         input bit also_wgo, output logic [CW-1:0] d);
    int            n;
    logic [CW-1:0] snap;
    @(negedge clk);
    host_rgo = 1'b1; host_wgo = also_wgo; corrected_address = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      read_noise();
      if (inj_wgo && n == 1) begin
        host_wgo = 1'b1;
        corrected_address = 32'h0000_01C0;
      end
    end while (host_rd_ready !== 1'b1 && n < 50);
    check("rd_ready_seen", host_rd_ready, 1'b1);
    check("rd_latency", n - 1, RDL);
    snap = host_data_bus_read_in;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      host_rgo = 1'b0; host_wgo = 1'b0; host_we = 1'b0;
      check("rd_hold_ready", host_rd_ready, 1'b1);
      check("rd_hold_data", host_data_bus_read_in, snap);
    end
    host_re = 1'b1;
    @(negedge clk);
    host_re = 1'b0; host_rgo = 1'b0; host_wgo = 1'b0; host_we = 1'b0;
    check("rd_drop", host_rd_ready, 1'b0);
    check("rd_data_clear", host_data_bus_read_in, '0);
    d = snap;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [CW-1:0] data, input int hold);
    int n;
    @(negedge clk);
    host_wgo = 1'b1; corrected_address = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      write_noise();
    end while (host_wr_ready !== 1'b1 && n < 50);
    check("wr_ready_seen", host_wr_ready, 1'b1);
    check("wr_latency", n - 1, WRL);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      host_rgo = 1'b0; host_wgo = 1'b0; host_re = 1'b0;
      check("wr_hold_ready", host_wr_ready, 1'b1);
    end
    host_we = 1'b1; host_data_bus_write_out = data;
    @(negedge clk);
    host_we = 1'b0; host_rgo = 1'b0; host_wgo = 1'b0; host_re = 1'b0;
    host_data_bus_write_out = {16{32'h0BAD_F00D}};
    check("wr_drop", host_wr_ready, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] d;
    logic [CW-1:0] pat;
    logic [CW-1:0] ones;
    logic [AW-1:0] a;
    int            e0;
    pat  = {16{32'hDEADBEEF}};
    ones = '1;

    repeat (3) @(negedge clk);
    check("rst_host_init", host_init, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_rd_ready", host_rd_ready, 1'b0);
    check("rst_wr_ready", host_wr_ready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data", host_data_bus_read_in, '0);

    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) begin
        check("init_still_low", host_init, 1'b0);
        check("init_busy_high", busy, 1'b1);
      end
      if (k == 64) begin
        check("init_rise", host_init, 1'b1);
        check("init_busy_low", busy, 1'b0);
      end
    end

    do_read(32'h0000_0140, 0, 1'b0, 1'b0, d);
    check("cleared_line5", d, '0);

    do_write(32'h0000_0140, pat, 0);
    do_read(32'h0000_0147, 20, 1'b0, 1'b0, d);
    check("wr_then_rd", d, pat);

    e0 = err_seen;
    do_read(32'h4000_0000, 0, 1'b0, 1'b0, d);
    repeat (2) @(negedge clk);
    check("oor_rd_err", err_seen - e0, 1);
    check("oor_rd_zero", d, '0);

    e0 = err_seen;
    do_read(32'h0000_0140, 0, 1'b0, 1'b1, d);
    repeat (2) @(negedge clk);
    check("both_go_err", err_seen - e0, 1);
    check("both_go_reads", d, pat);

    e0 = err_seen;
    do_read(32'h0000_0180, 0, 1'b1, 1'b0, d);
    repeat (2) @(negedge clk);
    check("busy_wgo_err", err_seen - e0, 1);
    do_read(32'h0000_01C0, 0, 1'b0, 1'b0, d);
    check("busy_wgo_dropped", d, '0);

    e0 = err_seen;
    do_write(32'h0001_0000, ones, 1);
    repeat (2) @(negedge clk);
    check("oor_wr_err", err_seen - e0, 1);
    do_read(32'h0000_0000, 0, 1'b0, 1'b0, d);
    check("oor_wr_discard", d, '0);

    noise_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(7) == 0) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(7) * 64 + $urandom_range(63));
      if ($urandom_range(1) == 1) begin
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        do_write(a, d, $urandom_range(3));
      end else begin
        do_read(a, $urandom_range(3), 1'b0, 1'b0, d);
      end
      repeat ($urandom_range(2)) @(negedge clk);
    end
    noise_en = 1'b0;

    do_write(32'h0000_0140, pat, 0);
    @(negedge clk);
    host_rgo = 1'b1; corrected_address = 32'h0000_0140;
    @(negedge clk);
    host_rgo = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_init", host_init, 1'b0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_rd_ready", host_rd_ready, 1'b0);
    check("midrst_wr_ready", host_wr_ready, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_data", host_data_bus_read_in, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    check("reinit_low", host_init, 1'b0);
    @(negedge clk);
    check("reinit_high", host_init, 1'b1);
    do_read(32'h0000_0140, 0, 1'b0, 1'b0, d);
    check("reinit_cleared", d, '0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
